// File: rtl/dclk_arb_pkg.sv
// Shared definitions for the ALU/bus arbiter of the timer PLAs.
// Contents:
//   REQ_SET / REQ_UPD / REQ_CMP  requester index constants
//   arb_state_t                  arbiter state enumeration
//   alu_op_t                     ALU operation codes carried on alu_s
//   HOLD_MAX_DEF                 default maximum grant length (clk cycles)
//   CNT_W                        width of the watchdog hold counter
package dclk_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_SET = 0;
  localparam int REQ_UPD = 1;
  localparam int REQ_CMP = 2;

  localparam int HOLD_MAX_DEF = 48;
  localparam int CNT_W        = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } arb_state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

endpackage

// File: rtl/arb_prio_enc.sv
// Fixed-priority one-hot encoder for the arbiter.
// Priority: time-update (bit1) > timer-compare (bit2) > timer-set (bit0).
// Ports:
//   elig  in  3  eligible requests (req with masked requesters removed)
//   pick  out 3  one-hot winner, zero when nothing is eligible
module arb_prio_enc
  import dclk_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    if (elig[REQ_UPD])      pick[REQ_UPD] = 1'b1;
    else if (elig[REQ_CMP]) pick[REQ_CMP] = 1'b1;
    else if (elig[REQ_SET]) pick[REQ_SET] = 1'b1;
  end

endmodule

// File: rtl/alu_bus_arbiter.sv
// Arbiter granting the shared ALU/bus to one of three timer PLAs.
// IDLE -> GRANT on any eligible request, GRANT -> TURN on done/release
// of the granted requester, TURN is a single turnaround cycle back to IDLE.
// Optional watchdog: define ARB_WATCHDOG_EN to bound the grant length to
// HOLD_MAX cycles; an expired requester is masked until it drops its req.
// Ports:
//   clk      in  1  clock, rising edge
//   clear    in  1  asynchronous active-high reset
//   req      in  3  requests (bit0 set, bit1 update, bit2 compare)
//   done     in  3  end-of-operation strobes, only granted bit is used
//   s_in     in  6  per-requester ALU select, requester i at [2i+1:2i]
//   cin_in   in  3  per-requester ALU carry-in
//   gnt      out 3  registered one-hot grant / PLA enable
//   alu_s    out 2  ALU select of the granted requester
//   alu_cin  out 1  carry-in of the granted requester
//   busy     out 1  high outside IDLE
//   timeout  out 1  one-cycle pulse when a grant is force-revoked
module alu_bus_arbiter
  import dclk_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   done,
  input  logic [2*NUM_REQ-1:0] s_in,
  input  logic [NUM_REQ-1:0]   cin_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [1:0]           alu_s,
  output logic                 alu_cin,
  output logic                 busy,
  output logic                 timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 63) begin : g_hold_chk
    $error("alu_bus_arbiter: HOLD_MAX out of range 2..63");
  end

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick;
  logic               g_done;
  logic               g_req;
  logic               expire;

  // gnt is one-hot, so AND-reduce-OR selects the granted requester's bit.
  assign g_done = |(done & gnt);
  assign g_req  = |(req & gnt);

`ifdef ARB_WATCHDOG_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0] mask;

  assign elig = req & ~mask;
  // A done or release in the expiry cycle wins: it is a normal completion.
  assign expire = (state == GRANT) && (hold_cnt == HOLD_LAST) && !g_done && g_req;

  // Counter is zero in IDLE, so the first GRANT cycle sees 0.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)               hold_cnt <= '0;
    else if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
    else                     hold_cnt <= '0;
  end

  // A low req clears its mask bit; an expiry masks the granted requester.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) mask <= '0;
    else       mask <= (mask & req) | (expire ? gnt : '0);
  end
`else
  assign elig   = req;
  assign expire = 1'b0;
`endif

  arb_prio_enc u_prio (
    .elig (elig),
    .pick (pick)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (|pick) begin
          gnt_nxt   = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (g_done || !g_req || expire) begin
          gnt_nxt   = '0;
          state_nxt = TURN;
        end
      end
      TURN: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    alu_s   = 2'b00;
    alu_cin = 1'b0;
    case (gnt)
      3'b001: begin alu_s = s_in[2*REQ_SET +: 2]; alu_cin = cin_in[REQ_SET]; end
      3'b010: begin alu_s = s_in[2*REQ_UPD +: 2]; alu_cin = cin_in[REQ_UPD]; end
      3'b100: begin alu_s = s_in[2*REQ_CMP +: 2]; alu_cin = cin_in[REQ_CMP]; end
      default: begin alu_s = 2'b00; alu_cin = 1'b0; end
    endcase
  end

  assign busy    = (state != IDLE);
  assign timeout = expire;

endmodule
